slice_coeff_seq: RTL and testbench

SLICE_COEFF_SEQ -- requirements
Module: slice_coeff_seq

---
 rtl/slice_coeff_seq.sv | 178 +++++++++++++++++
 tb/tb_slice_coeff_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_coeff_seq.sv
// slice_coeff_seq: feeds pixels and their per-position coefficients to an accumulator slice,
// then drains the slice FIFO once the frame has ended.
//
// Frame sequence: IDLE -> (sof) STREAM -> (eof) FLUSH (2 cycles) -> DRAIN (WPI cycles) -> IDLE.
//
// Ports
//   clk         single rising-edge clock
//   reset       synchronous active-high reset; the coefficient table is not reset
//   sof, eof    start / end of frame pulses (sof honoured only in IDLE, eof only in STREAM)
//   dvi         input pixel valid
//   data_in     input pixel
//   cfg_wr      coefficient table write strobe (honoured only in IDLE)
//   cfg_addr    coefficient table write address
//   cfg_data    signed coefficient to write
//   dvo         pixel valid toward the slice (1 cycle after dvi)
//   data        pixel toward the slice (held while dvo=0)
//   svcoeff     coefficient paired with data (held while dvo=0)
//   newblock    marks the last pixel of a block, qualified by dvo
//   download    slice drain/clear command, high for WPI cycles in DRAIN
//   regout      slice FIFO output
//   result_data regout captured on each download cycle, valid with result_dv
//   result_dv   download delayed by one cycle
//   busy        high whenever the sequencer is not in IDLE
module slice_coeff_seq #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned CWIDTH    = 9,
  parameter int unsigned BLOCKSIZE = 32,
  parameter int unsigned WINCOLS   = 8,
  parameter int unsigned WPI       = 40
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sof,
  input  logic                                   eof,
  input  logic                                   dvi,
  input  logic        [DWIDTH-1:0]               data_in,
  input  logic                                   cfg_wr,
  input  logic        [$clog2(BLOCKSIZE*WINCOLS)-1:0] cfg_addr,
  input  logic signed [CWIDTH-1:0]               cfg_data,
  output logic                                   dvo,
  output logic        [DWIDTH-1:0]               data,
  output logic signed [CWIDTH-1:0]               svcoeff,
  output logic                                   newblock,
  output logic                                   download,
  input  logic signed [31:0]                     regout,
  output logic signed [31:0]                     result_data,
  output logic                                   result_dv,
  output logic                                   busy
);

  localparam int unsigned Depth = BLOCKSIZE * WINCOLS;
  localparam int unsigned AW    = $clog2(Depth);
  localparam int unsigned PW    = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;
  localparam int unsigned BW    = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;
  localparam int unsigned DCW   = (WPI > 1) ? $clog2(WPI) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDrain} state_e;

  state_e                    state_q;
  logic        [PW-1:0]      pix_q;
  logic        [BW-1:0]      blk_q;
  logic                      flush_q;
  logic        [DCW-1:0]     drain_q;
  logic                      dvo_q;
  logic        [DWIDTH-1:0]  data_q;
  logic signed [CWIDTH-1:0]  svcoeff_q;
  logic                      newblock_q;
  logic                      download_q;
  logic signed [31:0]        result_data_q;
  logic                      result_dv_q;
  logic                      busy_q;

  logic signed [CWIDTH-1:0]  coef_q [Depth];

  logic        [PW+BW-1:0]   rd_cat;
  logic        [AW-1:0]      rd_addr;
  logic                      pix_last;
  logic                      blk_last;

  // BLOCKSIZE is a power of two, so blkcount*BLOCKSIZE+pixcount is a plain concatenation.
  assign rd_cat   = {blk_q, pix_q};
  assign rd_addr  = AW'(rd_cat);
  assign pix_last = (pix_q == PW'(BLOCKSIZE - 1));
  assign blk_last = (blk_q == BW'(WINCOLS - 1));

  // Coefficient table: no reset so contents survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (cfg_wr && (state_q == StIdle)) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pix_q         <= '0;
      blk_q         <= '0;
      flush_q       <= 1'b0;
      drain_q       <= '0;
      dvo_q         <= 1'b0;
      data_q        <= '0;
      svcoeff_q     <= '0;
      newblock_q    <= 1'b0;
      download_q    <= 1'b0;
      result_data_q <= '0;
      result_dv_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      dvo_q       <= 1'b0;
      newblock_q  <= 1'b0;
      result_dv_q <= download_q;
      // FIFO word presented during a download cycle is captured alongside result_dv.
      if (download_q) begin
        result_data_q <= regout;
      end

      unique case (state_q)
        StIdle: begin
          if (sof) begin
            state_q <= StStream;
            pix_q   <= '0;
            blk_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StStream: begin
          if (dvi) begin
            dvo_q      <= 1'b1;
            data_q     <= data_in;
            svcoeff_q  <= coef_q[rd_addr];
            newblock_q <= pix_last;
            if (pix_last) begin
              pix_q <= '0;
              blk_q <= blk_last ? '0 : blk_q + BW'(1);
            end else begin
              pix_q <= pix_q + PW'(1);
            end
          end
          // A pixel coincident with eof has already been accepted above.
          if (eof) begin
            state_q <= StFlush;
            flush_q <= 1'b0;
          end
        end
        StFlush: begin
          // Two idle cycles let the slice's multiplier stage settle before draining.
          if (flush_q) begin
            state_q    <= StDrain;
            drain_q    <= '0;
            download_q <= 1'b1;
          end else begin
            flush_q <= 1'b1;
          end
        end
        StDrain: begin
          if (drain_q == DCW'(WPI - 1)) begin
            state_q    <= StIdle;
            download_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            drain_q <= drain_q + DCW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dvo         = dvo_q;
  assign data        = data_q;
  assign svcoeff     = svcoeff_q;
  assign newblock    = newblock_q;
  assign download    = download_q;
  assign result_data = result_data_q;
  assign result_dv   = result_dv_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_slice_coeff_seq.sv
module tb_slice_coeff_seq;

  localparam int BS    = 32;
  localparam int WC    = 8;
  localparam int DEPTH = BS * WC;
  localparam int WPI   = 40;

  logic               clk;
  logic               reset;
  logic               sof;
  logic               eof;
  logic               dvi;
  logic        [7:0]  data_in;
  logic               cfg_wr;
  logic        [7:0]  cfg_addr;
  logic signed [8:0]  cfg_data;
  logic               dvo;
  logic        [7:0]  data;
  logic signed [8:0]  svcoeff;
  logic               newblock;
  logic               download;
  logic signed [31:0] regout;
  logic signed [31:0] result_data;
  logic               result_dv;
  logic               busy;

  int checks;
  int errors;

  // Reference state: coefficient table contents and the last pixel/coef seen on the output.
  logic signed [8:0] mdl_coef [DEPTH];
  logic        [7:0] last_data;
  logic signed [8:0] last_coef;

  slice_coeff_seq dut (
    .clk         (clk),
    .reset       (reset),
    .sof         (sof),
    .eof         (eof),
    .dvi         (dvi),
    .data_in     (data_in),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .dvo         (dvo),
    .data        (data),
    .svcoeff     (svcoeff),
    .newblock    (newblock),
    .download    (download),
    .regout      (regout),
    .result_data (result_data),
    .result_dv   (result_dv),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input bit random_vals);
    for (int i = 0; i < DEPTH; i++) begin
      logic signed [8:0] v;
      v = random_vals ? 9'($urandom) : 9'(i - 128);
      mdl_coef[i] = v;
      cfg_wr   = 1'b1;
      cfg_addr = 8'(i);
      cfg_data = v;
      step();
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL reset_dvo got %b exp 0", dvo); end
    checks++; if (newblock !== 1'b0) begin errors++; $display("FAIL reset_newblock got %b exp 0", newblock); end
    checks++; if (download !== 1'b0) begin errors++; $display("FAIL reset_download got %b exp 0", download); end
    checks++; if (result_dv !== 1'b0) begin errors++; $display("FAIL reset_result_dv got %b exp 0", result_dv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", data); end
    checks++; if (svcoeff !== 9'sd0) begin errors++; $display("FAIL reset_svcoeff got %0d exp 0", svcoeff); end
    checks++; if (result_data !== 32'sd0) begin errors++; $display("FAIL reset_result_data got %0d exp 0", result_data); end
    reset = 1'b0;
    last_data = '0;
    last_coef = '0;
  endtask

  // gap_mode: 0 continuous, 1 alternate cycles, 2 random gaps.
  task automatic stream_frame(input int n, input int gap_mode, input bit eof_dvi, input bit cfg_noise);
    int k;
    int c;
    bit v;
    logic [7:0] d;
    logic signed [8:0] exp_coef;
    sof = 1'b1;
    step();
    sof = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sof_busy got %b exp 1", busy); end
    checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL sof_dvo got %b exp 0", dvo); end
    k = 0;
    c = 0;
    while (k < n && c < 8 * n + 16) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      d       = 8'($urandom);
      dvi     = v;
      data_in = d;
      eof     = v && eof_dvi && (k == n - 1);
      if (cfg_noise) begin
        cfg_wr   = 1'b1;
        cfg_addr = 8'($urandom);
        cfg_data = 9'($urandom);
      end
      step();
      if (v) begin
        exp_coef = mdl_coef[k % DEPTH];
        checks++; if (dvo !== 1'b1) begin errors++; $display("FAIL px_dvo k=%0d got %b exp 1", k, dvo); end
        checks++; if (data !== d) begin errors++; $display("FAIL px_data k=%0d got %0d exp %0d", k, data, d); end
        checks++; if (svcoeff !== exp_coef) begin errors++; $display("FAIL px_svcoeff k=%0d got %0d exp %0d", k, svcoeff, exp_coef); end
        checks++; if (newblock !== ((k % BS) == BS - 1)) begin errors++; $display("FAIL px_newblock k=%0d got %b exp %b", k, newblock, ((k % BS) == BS - 1)); end
        last_data = d;
        last_coef = exp_coef;
        k++;
      end else begin
        checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL gap_dvo k=%0d got %b exp 0", k, dvo); end
        checks++; if (newblock !== 1'b0) begin errors++; $display("FAIL gap_newblock k=%0d got %b exp 0", k, newblock); end
        checks++; if (data !== last_data) begin errors++; $display("FAIL gap_data_hold got %0d exp %0d", data, last_data); end
        checks++; if (svcoeff !== last_coef) begin errors++; $display("FAIL gap_coef_hold got %0d exp %0d", svcoeff, last_coef); end
      end
      c++;
    end
    dvi    = 1'b0;
    eof    = 1'b0;
    cfg_wr = 1'b0;
    checks++; if (k != n) begin errors++; $display("FAIL stream_budget got %0d pixels exp %0d", k, n); end
    if (!eof_dvi) begin
      eof = 1'b1;
      step();
      eof = 1'b0;
      checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL eof_dvo got %b exp 0", dvo); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL eof_busy got %b exp 1", busy); end
    end
  endtask

  // Observation m=0 is the cycle right after eof was taken. FLUSH covers m=0..1,
  // download m=2..41, result_dv m=3..42. abort_m/sof_m < 0 disables those events.
  task automatic drain_phase(input int abort_m, input int sof_m);
    bit aborted;
    bit e_dl;
    bit e_rv;
    bit e_busy;
    aborted = 1'b0;
    regout  = 32'($urandom);
    for (int m = 0; m <= 44; m++) begin
      if (m > 0) step();
      if (aborted) begin
        e_dl = 1'b0; e_rv = 1'b0; e_busy = 1'b0;
      end else begin
        e_dl   = (m >= 2 && m <= 1 + WPI);
        e_rv   = (m >= 3 && m <= 2 + WPI);
        e_busy = (m <= 1 + WPI);
      end
      checks++; if (download !== e_dl) begin errors++; $display("FAIL drain_download m=%0d got %b exp %b", m, download, e_dl); end
      checks++; if (result_dv !== e_rv) begin errors++; $display("FAIL drain_result_dv m=%0d got %b exp %b", m, result_dv, e_rv); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL drain_busy m=%0d got %b exp %b", m, busy, e_busy); end
      if (m > 0) begin
        checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL drain_dvo m=%0d got %b exp 0", m, dvo); end
      end
      if (e_rv) begin
        checks++; if (result_data !== regout) begin errors++; $display("FAIL drain_result_data m=%0d got %0d exp %0d", m, result_data, regout); end
      end
      if (aborted) begin
        checks++; if (result_data !== 32'sd0) begin errors++; $display("FAIL abort_result_data m=%0d got %0d exp 0", m, result_data); end
      end
      sof = (m == sof_m);
      if (m == abort_m) begin
        reset   = 1'b1;
        aborted = 1'b1;
      end else begin
        reset = 1'b0;
      end
      regout = 32'($urandom);
    end
    sof    = 1'b0;
    reset  = 1'b0;
    regout = '0;
    if (aborted) begin
      last_data = '0;
      last_coef = '0;
    end
  endtask

  task automatic test_stream();
    load_table(1'b0);
    stream_frame(DEPTH, 0, 1'b1, 1'b0);
    drain_phase(-1, -1);
  endtask

  task automatic test_gapped();
    stream_frame(DEPTH, 1, 1'b1, 1'b0);
    drain_phase(-1, -1);
    stream_frame(100, 2, 1'b0, 1'b0);
    drain_phase(-1, -1);
  endtask

  task automatic test_cfg_in_stream();
    stream_frame(DEPTH, 0, 1'b1, 1'b1);
    drain_phase(-1, -1);
    stream_frame(DEPTH, 2, 1'b1, 1'b0);
    drain_phase(-1, -1);
  endtask

  task automatic test_reset_in_drain();
    stream_frame(70, 0, 1'b1, 1'b0);
    drain_phase(12, -1);
    stream_frame(DEPTH, 0, 1'b1, 1'b0);
    drain_phase(-1, -1);
  endtask

  task automatic test_sof_in_drain();
    stream_frame(45, 2, 1'b1, 1'b0);
    drain_phase(-1, 10);
  endtask

  task automatic test_idle_ignore();
    eof     = 1'b1;
    dvi     = 1'b1;
    data_in = 8'hA5;
    step();
    eof = 1'b0;
    dvi = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_eof_busy got %b exp 0", busy); end
    checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL idle_dvi_dvo got %b exp 0", dvo); end
    checks++; if (data !== last_data) begin errors++; $display("FAIL idle_data_hold got %0d exp %0d", data, last_data); end
  endtask

  task automatic test_random_table();
    load_table(1'b1);
    stream_frame(DEPTH + 37, 2, 1'b0, 1'b0);
    drain_phase(-1, -1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    sof      = 1'b0;
    eof      = 1'b0;
    dvi      = 1'b0;
    data_in  = '0;
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    regout   = '0;
    test_reset();
    test_stream();
    test_gapped();
    test_cfg_in_stream();
    test_reset_in_drain();
    test_sof_in_drain();
    test_idle_ignore();
    test_random_table();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
